// File: rtl/load_buffer_pkg.sv
// Shared types for the load buffer: entry/CDB packet layouts, FSM states and
// the default depth.
package load_buffer_pkg;

  localparam int XLEN         = 32;
  localparam int TAG_W        = 5;
  localparam int LB_DEPTH_DEF = 4;

  localparam logic [XLEN-1:0] BAD_LOAD_VALUE = 32'hdeadfbac;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WB    = 2'd2,
    DRAIN = 2'd3
  } LB_STATE;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  address;
    logic [TAG_W-1:0] rd_tag;
    logic [2:0]       mem_size;
    logic [XLEN-1:0]  NPC;
    logic [31:0]      inst;
  } LB_PACKET;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]  NPC;
    logic [31:0]      inst;
  } EX_WR_PACKET;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Extracts and extends the loaded byte/halfword/word from a returned memory
// word according to the funct3 size code and the low address bits.
module load_data_align
  import load_buffer_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      address,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] result
);

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
    return XLEN'(b);
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return XLEN'(b);
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
    return XLEN'(h);
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
    return XLEN'(h);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (address)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = address[1] ? word[31:16] : word[15:0];

    case (mem_size)
      3'b000:  result = sext8(byte_sel);
      3'b100:  result = zext8(byte_sel);
      3'b001:  result = sext16(half_sel);
      3'b101:  result = zext16(half_sel);
      3'b010:  result = word;
      default: result = BAD_LOAD_VALUE;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: circular FIFO of pending loads, one outstanding memory
// read for the head entry, aligned result broadcast on the CDB until granted.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  LB_PACKET        lb_packet_in,
  output logic            lb_full,
  input  logic            squash,
  input  logic            mem_block,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output EX_WR_PACKET     lb_output,
  input  logic            cdb_grant
);

  localparam int PTR_W = $clog2(LB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  LB_STATE          state, state_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  wb_value;
  logic [XLEN-1:0]  aligned;
  logic             enq, pop, capture;

  logic [XLEN-1:0]  addr_q [LB_DEPTH];
  logic [TAG_W-1:0] tag_q  [LB_DEPTH];
  logic [2:0]       size_q [LB_DEPTH];
  logic [XLEN-1:0]  npc_q  [LB_DEPTH];
  logic [31:0]      inst_q [LB_DEPTH];

  assign lb_full = (count == CNT_W'(LB_DEPTH));
  // A full buffer drops the incoming load even if the head retires this cycle.
  assign enq     = lb_packet_in.valid & ~lb_full & ~squash;

  load_data_align u_align (
    .word     (mem_resp_data),
    .address  (addr_q[head][1:0]),
    .mem_size (size_q[head]),
    .result   (aligned)
  );

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    mem_req_addr  = word_addr(addr_q[head]);
    lb_output     = '0;
    pop           = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        mem_req_valid = (count != '0) & ~mem_block;
        // A request accepted in the same cycle as a flush still owes a response.
        if (squash)
          state_nxt = (mem_req_valid & mem_req_ready) ? DRAIN : IDLE;
        else if (mem_req_valid & mem_req_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (squash)
          state_nxt = mem_resp_valid ? IDLE : DRAIN;
        else if (mem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = WB;
        end
      end
      WB: begin
        lb_output.valid   = 1'b1;
        lb_output.value   = wb_value;
        lb_output.rob_tag = tag_q[head];
        lb_output.NPC     = npc_q[head];
        lb_output.inst    = inst_q[head];
        if (squash)
          state_nxt = IDLE;
        else if (cdb_grant) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (mem_resp_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail] <= lb_packet_in.address;
      tag_q[tail]  <= lb_packet_in.rd_tag;
      size_q[tail] <= lb_packet_in.mem_size;
      npc_q[tail]  <= lb_packet_in.NPC;
      inst_q[tail] <= lb_packet_in.inst;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_value <= '0;
    end else begin
      state <= state_nxt;
      if (capture)
        wb_value <= aligned;
      if (squash) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq)
          tail <= tail + PTR_W'(1);
        if (pop)
          head <= head + PTR_W'(1);
        case ({enq, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_load_buffer;
  import load_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  LB_PACKET        lb_packet_in;
  logic            lb_full;
  logic            squash;
  logic            mem_block;
  logic            mem_req_valid;
  logic [31:0]     mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid = 1'b0;
  logic [31:0]     mem_resp_data = '0;
  EX_WR_PACKET     lb_output;
  logic            cdb_grant;

  always #5 clock = ~clock;

  load_buffer #(.LB_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .lb_packet_in   (lb_packet_in),
    .lb_full        (lb_full),
    .squash         (squash),
    .mem_block      (mem_block),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .lb_output      (lb_output),
    .cdb_grant      (cdb_grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed word for directed tests, otherwise a hash of the word address.
  bit          fixed_en = 0;
  logic [31:0] fixed_word = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (fixed_en) return fixed_word;
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [2:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * lo));
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return 32'hdeadfbac;
    endcase
  endfunction

  // Memory responder: one response per accepted request, after resp_lat idle cycles.
  bit          hs_seen = 0;
  logic [31:0] hs_addr = '0;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          resp_lat = 0;
  bit          lat_rand = 0;

  always @(posedge clock) begin
    #1;
    mem_resp_valid = 1'b0;
    if (hs_seen) begin
      pend      = 1;
      pend_addr = hs_addr;
      pend_cnt  = lat_rand ? int'($urandom_range(0, 3)) : resp_lat;
      hs_seen   = 0;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(pend_addr);
        pend           = 0;
      end else begin
        pend_cnt--;
      end
    end
  end

  // Reference model: the ordered list of loads the buffer currently holds.
  LB_PACKET mq[$];

  always @(negedge clock) begin
    bit full_before;
    if (!reset_n) begin
      mq.delete();
      chk("rst_out_valid", 32'(lb_output.valid), 0);
      chk("rst_full", 32'(lb_full), 0);
      chk("rst_req_valid", 32'(mem_req_valid), 0);
    end else begin
      chk("full", 32'(lb_full), 32'(mq.size() == DEPTH));
      if (mem_req_valid) begin
        chk("req_nonempty", 32'(mq.size() != 0), 1);
        chk("req_blocked", 32'(mem_block), 0);
        if (mq.size() != 0)
          chk("req_addr", mem_req_addr, {mq[0].address[31:2], 2'b00});
        if (mem_req_ready) begin
          hs_seen = 1;
          hs_addr = mem_req_addr;
        end
      end
      if (lb_output.valid) begin
        chk("out_nonempty", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          chk("out_value", lb_output.value,
              ref_align(mem_word(mq[0].address), mq[0].address[1:0], mq[0].mem_size));
          chk("out_tag", 32'(lb_output.rob_tag), 32'(mq[0].rd_tag));
          chk("out_npc", lb_output.NPC, mq[0].NPC);
          chk("out_inst", lb_output.inst, mq[0].inst);
        end
      end else begin
        chk("out_zero", 32'(lb_output != '0), 0);
      end
      full_before = (mq.size() == DEPTH);
      if (squash) begin
        mq.delete();
      end else begin
        if (lb_output.valid && cdb_grant && mq.size() != 0)
          void'(mq.pop_front());
        if (lb_packet_in.valid && !full_before)
          mq.push_back(lb_packet_in);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] addr, input logic [2:0] sz, input logic [4:0] tag);
    lb_packet_in.valid    = 1'b1;
    lb_packet_in.address  = addr;
    lb_packet_in.mem_size = sz;
    lb_packet_in.rd_tag   = tag;
    lb_packet_in.NPC      = addr + 32'd4;
    lb_packet_in.inst     = $urandom;
    tick();
    lb_packet_in.valid = 1'b0;
  endtask

  task automatic wait_out(input string name, output EX_WR_PACKET o);
    bit got;
    got = 0;
    o   = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (lb_output.valid) begin
        got = 1;
        o   = lb_output;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: lb_output.valid not seen within 60 cycles, required 1", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    EX_WR_PACKET o, o1;
    lb_packet_in  = '0;
    squash        = 1'b0;
    mem_block     = 1'b0;
    mem_req_ready = 1'b1;
    cdb_grant     = 1'b1;

    #2 reset_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(lb_output.valid), 0);
    chk("reset_full", 32'(lb_full), 0);
    chk("reset_req_valid", 32'(mem_req_valid), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Single LW, minimum latency.
    fixed_en = 1; fixed_word = 32'h12345678; resp_lat = 0;
    enq(32'h1004, 3'b010, 5'd7);
    @(negedge clock);
    chk("lw_req_valid_n1", 32'(mem_req_valid), 1);
    chk("lw_req_addr", mem_req_addr, 32'h1004);
    tick();
    @(negedge clock);
    chk("lw_out_n2", 32'(lb_output.valid), 0);
    tick();
    @(negedge clock);
    chk("lw_out_n3", 32'(lb_output.valid), 1);
    chk("lw_value", lb_output.value, 32'h12345678);
    chk("lw_tag", 32'(lb_output.rob_tag), 7);
    tick();

    // Sub-word alignment.
    fixed_word = 32'h80FFFF00;
    enq(32'h1003, 3'b000, 5'd1); wait_out("lb", o); chk("lb_value", o.value, 32'hFFFFFF80); tick();
    enq(32'h1003, 3'b100, 5'd2); wait_out("lbu", o); chk("lbu_value", o.value, 32'h00000080); tick();
    enq(32'h1002, 3'b101, 5'd3); wait_out("lhu", o); chk("lhu_value", o.value, 32'h000080FF); tick();
    enq(32'h1002, 3'b001, 5'd4); wait_out("lh", o); chk("lh_value", o.value, 32'hFFFF80FF); tick();
    enq(32'h1001, 3'b011, 5'd5); wait_out("bad", o); chk("bad_value", o.value, 32'hdeadfbac); tick();
    fixed_en = 0;

    // Fill with memory stalled; fifth load dropped.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lb_packet_in.valid    = 1'b1;
      lb_packet_in.address  = 32'h2000 + 32'(16 * i);
      lb_packet_in.mem_size = 3'b010;
      lb_packet_in.rd_tag   = 5'(10 + i);
      lb_packet_in.NPC      = 32'h8000 + 32'(4 * i);
      lb_packet_in.inst     = $urandom;
      tick();
      if (i == 3) chk("full_after_4", 32'(lb_full), 1);
    end
    lb_packet_in.valid = 1'b0;
    chk("full_after_5", 32'(lb_full), 1);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_out("fill_out", o);
      chk("fill_order", 32'(o.rob_tag), 32'(10 + k));
      tick();
    end
    repeat (3) tick();
    chk("full_cleared", 32'(lb_full), 0);

    // Squash in WAIT, response 3 cycles later.
    resp_lat = 3;
    enq(32'h3000, 3'b010, 5'd20);
    tick();
    squash = 1'b1;
    tick();
    squash = 1'b0;
    enq(32'h3400, 3'b010, 5'd21);
    @(negedge clock);
    chk("drain_no_req_a", 32'(mem_req_valid), 0);
    tick();
    @(negedge clock);
    chk("drain_no_req_b", 32'(mem_req_valid), 0);
    chk("drain_no_out", 32'(lb_output.valid), 0);
    resp_lat = 0;
    wait_out("after_drain", o);
    chk("after_drain_tag", 32'(o.rob_tag), 21);
    tick();

    // mem_block holds requests; withheld grant keeps lb_output stable.
    mem_block = 1'b1;
    enq(32'h4000, 3'b010, 5'd30);
    enq(32'h4011, 3'b000, 5'd31);
    repeat (3) begin
      @(negedge clock);
      chk("blocked_no_req", 32'(mem_req_valid), 0);
      tick();
    end
    mem_block = 1'b0;
    cdb_grant = 1'b0;
    wait_out("hold_first", o1);
    chk("hold_first_tag", 32'(o1.rob_tag), 30);
    repeat (4) begin
      tick();
      @(negedge clock);
      chk("hold_valid", 32'(lb_output.valid), 1);
      chk("hold_value", lb_output.value, o1.value);
      chk("hold_tag", 32'(lb_output.rob_tag), 30);
    end
    tick();
    cdb_grant = 1'b1;
    tick();
    wait_out("hold_second", o);
    chk("hold_second_tag", 32'(o.rob_tag), 31);
    tick();

    // Reset while in WB.
    cdb_grant = 1'b0;
    enq(32'h5000, 3'b010, 5'd40);
    wait_out("rst_wb", o);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(lb_output.valid), 0);
    chk("rst_wb_full", 32'(lb_full), 0);
    tick();
    tick();
    reset_n = 1'b1;
    cdb_grant = 1'b1;
    tick();

    // Reset while waiting for a response; the late response is ignored.
    resp_lat = 3;
    enq(32'h6000, 3'b010, 5'd41);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("late_resp_ignored", 32'(lb_output.valid), 0);
    resp_lat = 0;

    // Randomized traffic.
    lat_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      lb_packet_in.valid    = ($urandom_range(0, 9) < 6);
      lb_packet_in.address  = $urandom;
      lb_packet_in.mem_size = 3'($urandom_range(0, 7));
      lb_packet_in.rd_tag   = 5'($urandom);
      lb_packet_in.NPC      = $urandom;
      lb_packet_in.inst     = $urandom;
      mem_req_ready         = ($urandom_range(0, 9) < 7);
      cdb_grant             = ($urandom_range(0, 9) < 7);
      mem_block             = ($urandom_range(0, 9) < 2);
      squash                = ($urandom_range(0, 39) == 0);
      tick();
    end
    lb_packet_in.valid = 1'b0;
    squash        = 1'b0;
    mem_block     = 1'b0;
    mem_req_ready = 1'b1;
    cdb_grant     = 1'b1;
    for (int c = 0; c < 200 && mq.size() != 0; c++) tick();
    chk("final_drained", 32'(mq.size()), 0);
    repeat (6) tick();
    chk("final_full", 32'(lb_full), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
